// File: rtl/maze_pkg.sv
// Shared types and constants for the maze stream driver and its path checker.
package maze_pkg;

    localparam int MAZE_N    = 15;
    localparam int MAZE_BITS = MAZE_N * MAZE_N;

    typedef logic [3:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SEND,
        WAIT,
        PATH,
        DONE
    } drv_state_e;

    typedef enum logic [2:0] {
        FAIL_OK      = 3'd0,
        FAIL_ADJ     = 3'd1,
        FAIL_WALL    = 3'd2,
        FAIL_TIMEOUT = 3'd3,
        FAIL_START   = 3'd4,
        FAIL_LONG    = 3'd6
    } fail_e;

    localparam coord_t      START_XY  = 4'd13;
    localparam coord_t      GOAL_XY   = 4'd1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Flat image index of cell (x,y); x varies fastest.
    function automatic logic [7:0] cell_idx(input coord_t x, input coord_t y);
        return 8'(y) * 8'(MAZE_N) + 8'(x);
    endfunction

endpackage

// File: rtl/maze_path_checker.sv
// Per-beat legality check of one returned path coordinate against the maze image.
// Priority: wrong first cell, then non-adjacent step, then wall/out-of-range cell.
module maze_path_checker
    import maze_pkg::*;
(
    input  logic [MAZE_BITS-1:0] img_i,
    input  logic                 first_i,
    input  coord_t               prev_x_i,
    input  coord_t               prev_y_i,
    input  coord_t               cur_x_i,
    input  coord_t               cur_y_i,
    output fail_e                err_o,
    output logic                 goal_hit_o
);

    coord_t     dx, dy;
    logic       adj, in_rng, wall;
    logic [7:0] idx;

    // Classify the new coordinate relative to the previous one and the image.
    always_comb begin
        dx     = (cur_x_i > prev_x_i) ? cur_x_i - prev_x_i : prev_x_i - cur_x_i;
        dy     = (cur_y_i > prev_y_i) ? cur_y_i - prev_y_i : prev_y_i - cur_y_i;
        adj    = ((dx == 4'd1) && (dy == 4'd0)) || ((dx == 4'd0) && (dy == 4'd1));
        in_rng = (cur_x_i < 4'(MAZE_N)) && (cur_y_i < 4'(MAZE_N));
        idx    = in_rng ? cell_idx(cur_x_i, cur_y_i) : 8'd0;
        // Cells outside the grid are treated as wall.
        wall   = !in_rng || img_i[idx];
        err_o  = FAIL_OK;
        if (first_i && !((cur_x_i == START_XY) && (cur_y_i == START_XY)))
            err_o = FAIL_START;
        else if (!first_i && !adj)
            err_o = FAIL_ADJ;
        else if (wall)
            err_o = FAIL_WALL;
        goal_hit_o = (err_o == FAIL_OK) && (cur_x_i == GOAL_XY) && (cur_y_i == GOAL_XY);
    end

endmodule

// File: rtl/maze_stream_driver.sv
// Maze stream driver: holds a 15x15 wall image, streams it bit-serially to the
// solver on start, then captures and checks the solver's returned path.
// Optional feature macro: MAZE_LFSR_GEN_EN (start with gen_rand_i=1 first fills
// the image from a 16-bit Fibonacci LFSR before streaming).
module maze_stream_driver
    import maze_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we_i,
    input  logic [3:0]   cfg_row_i,
    input  logic [14:0]  cfg_data_i,
    input  logic         start_i,
    input  logic         gen_rand_i,
    output logic         maze_o,
    output logic         in_valid_o,
    input  logic         out_valid_i,
    input  logic         maze_not_valid_i,
    input  logic [3:0]   out_x_i,
    input  logic [3:0]   out_y_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic         nv_seen_o,
    output logic [2:0]   fail_code_o,
    output logic [3:0]   hdr_step_o,
    output logic [7:0]   path_len_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    drv_state_e             state_q;
    logic [MAZE_BITS-1:0]   img_q, img_d;
    logic [7:0]             bit_q;
    logic [TW-1:0]          tmo_q;
    coord_t                 prev_x_q, prev_y_q;
    logic                   maze_q, in_valid_q, busy_q, done_q, pass_q, nv_q;
    fail_e                  fail_q;
    coord_t                 hdr_q;
    logic [7:0]             len_q;

    fail_e                  chk_err;
    logic                   chk_goal;
    logic                   fin, fin_pass, fin_nv, tmo_hit;
    fail_e                  fin_code;

`ifdef MAZE_LFSR_GEN_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb, gen_bit;
    coord_t      gx, gy;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Generated cell value: border forced to wall, start/goal cells forced open.
    always_comb begin
        gx      = 4'(bit_q % 8'd15);
        gy      = 4'(bit_q / 8'd15);
        gen_bit = lfsr_fb;
        if ((gx == 4'd0) || (gx == 4'(MAZE_N - 1)) || (gy == 4'd0) || (gy == 4'(MAZE_N - 1)))
            gen_bit = 1'b1;
        else if (((gx == GOAL_XY) && (gy == GOAL_XY)) || ((gx == START_XY) && (gy == START_XY)))
            gen_bit = 1'b0;
    end

    // LFSR advances one step per generated cell; only reset reseeds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                lfsr_q <= LFSR_SEED;
        else if (state_q == GEN)   lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
`else
    logic unused_gen_rand;
    assign unused_gen_rand = gen_rand_i;
`endif

    // Next image: row writes only while idle, generated cells during fill.
    always_comb begin
        img_d = img_q;
        if ((state_q == IDLE) && cfg_we_i && (cfg_row_i != 4'd15))
            img_d[int'(cfg_row_i) * MAZE_N +: MAZE_N] = cfg_data_i;
`ifdef MAZE_LFSR_GEN_EN
        if (state_q == GEN)
            img_d[bit_q] = gen_bit;
`endif
    end

    // Image storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        img_q <= img_d;
    end

    maze_path_checker u_chk (
        .img_i      (img_q),
        .first_i    (len_q == 8'd0),
        .prev_x_i   (prev_x_q),
        .prev_y_i   (prev_y_q),
        .cur_x_i    (out_x_i),
        .cur_y_i    (out_y_i),
        .err_o      (chk_err),
        .goal_hit_o (chk_goal)
    );

    // Decide whether the response check ends this cycle and with what result.
    always_comb begin
        fin      = 1'b0;
        fin_pass = 1'b0;
        fin_nv   = 1'b0;
        fin_code = FAIL_OK;
        tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
        if ((state_q == WAIT) || (state_q == PATH)) begin
            if (maze_not_valid_i) begin
                fin    = 1'b1;
                fin_nv = 1'b1;
            end else if ((state_q == PATH) && out_valid_i && (chk_err != FAIL_OK)) begin
                fin      = 1'b1;
                fin_code = chk_err;
            end else if ((state_q == PATH) && out_valid_i && chk_goal) begin
                fin      = 1'b1;
                fin_pass = 1'b1;
            end else if ((state_q == PATH) && out_valid_i && (len_q == 8'hFF)) begin
                fin      = 1'b1;
                fin_code = FAIL_LONG;
            end else if (tmo_hit) begin
                fin      = 1'b1;
                fin_code = FAIL_TIMEOUT;
            end
        end
    end

    // Main FSM: serializer, header/path capture, timeout and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            tmo_q      <= '0;
            prev_x_q   <= '0;
            prev_y_q   <= '0;
            maze_q     <= 1'b0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            nv_q       <= 1'b0;
            fail_q     <= FAIL_OK;
            hdr_q      <= '0;
            len_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        nv_q     <= 1'b0;
                        fail_q   <= FAIL_OK;
                        hdr_q    <= '0;
                        len_q    <= '0;
                        tmo_q    <= '0;
`ifdef MAZE_LFSR_GEN_EN
                        if (gen_rand_i) begin
                            state_q <= GEN;
                            bit_q   <= '0;
                        end else
`endif
                        begin
                            // img_d carries a same-cycle row write into bit 0.
                            state_q    <= SEND;
                            maze_q     <= img_d[0];
                            in_valid_q <= 1'b1;
                            bit_q      <= 8'd1;
                        end
                    end
                end
`ifdef MAZE_LFSR_GEN_EN
                GEN: begin
                    if (bit_q == 8'(MAZE_BITS - 1)) begin
                        state_q    <= SEND;
                        maze_q     <= img_d[0];
                        in_valid_q <= 1'b1;
                        bit_q      <= 8'd1;
                    end else begin
                        bit_q <= bit_q + 8'd1;
                    end
                end
`endif
                SEND: begin
                    if (bit_q == 8'(MAZE_BITS)) begin
                        state_q    <= WAIT;
                        maze_q     <= 1'b0;
                        in_valid_q <= 1'b0;
                        tmo_q      <= '0;
                    end else begin
                        maze_q <= img_q[bit_q];
                        bit_q  <= bit_q + 8'd1;
                    end
                end
                WAIT, PATH: begin
                    tmo_q <= tmo_q + 1'b1;
                    if ((state_q == WAIT) && out_valid_i && !maze_not_valid_i) begin
                        hdr_q   <= out_x_i;
                        state_q <= PATH;
                    end
                    if ((state_q == PATH) && out_valid_i && !maze_not_valid_i) begin
                        if (len_q != 8'hFF) len_q <= len_q + 8'd1;
                        prev_x_q <= out_x_i;
                        prev_y_q <= out_y_i;
                    end
                    if (fin) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= fin_pass;
                        nv_q    <= fin_nv;
                        fail_q  <= fin_code;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign maze_o      = maze_q;
    assign in_valid_o  = in_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign nv_seen_o   = nv_q;
    assign fail_code_o = fail_q;
    assign hdr_step_o  = hdr_q;
    assign path_len_o  = len_q;

endmodule

// File: tb/tb_maze_stream_driver.sv
// Self-checking bench for maze_stream_driver: directed corridor scenarios plus
// randomized mazes/paths checked against a behavioural path model.
module tb_maze_stream_driver;

    localparam int TO = 4096;

    typedef struct {
        bit         nv;
        bit         ov;
        logic [3:0] x;
        logic [3:0] y;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we, start, gen_rand, out_valid, mnv;
    logic [3:0]  cfg_row, out_x, out_y;
    logic [14:0] cfg_data;
    logic        maze, in_valid, busy, done, pass, nv_seen;
    logic [2:0]  fail_code;
    logic [3:0]  hdr_step;
    logic [7:0]  path_len;

    maze_stream_driver #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_row_i(cfg_row),
        .cfg_data_i(cfg_data), .start_i(start), .gen_rand_i(gen_rand),
        .maze_o(maze), .in_valid_o(in_valid), .out_valid_i(out_valid),
        .maze_not_valid_i(mnv), .out_x_i(out_x), .out_y_i(out_y),
        .busy_o(busy), .done_o(done), .pass_o(pass), .nv_seen_o(nv_seen),
        .fail_code_o(fail_code), .hdr_step_o(hdr_step), .path_len_o(path_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit ref_img [15][15];   // [y][x], 1 = wall

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: in_valid falling edge time, done pulse capture, post-done behaviour.
    int   done_cnt = 0, done_cyc = 0, fall_cyc = 0;
    logic prev_iv = 1'b0, post_done = 1'b0;
    logic r_pass, r_nv;
    logic [2:0] r_code;
    logic [3:0] r_hdr;
    logic [7:0] r_len;

    always @(negedge clk) begin
        prev_iv   <= in_valid;
        post_done <= done;
        if (prev_iv && !in_valid) fall_cyc <= cyc;
        if (post_done && rst_n) begin
            chk("busy_after_done", busy, 1'b0);
            chk("done_one_cycle", done, 1'b0);
        end
        if (done) begin
            chk("busy_during_done", busy, 1'b1);
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            r_pass   <= pass;
            r_nv     <= nv_seen;
            r_code   <= fail_code;
            r_hdr    <= hdr_step;
            r_len    <= path_len;
        end
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Path model straight from the response rules; ee = index of ending beat, -1 = timeout.
    task automatic model(input beat_t b[$], output int ep, output int en, output int ec,
                         output int eh, output int el, output int ee);
        int n = 0, px = 0, py = 0, x, y;
        bit hd = 0;
        ep = 0; en = 0; ec = 0; eh = 0; el = 0; ee = -1;
        foreach (b[i]) begin
            if (b[i].nv) begin en = 1; ee = i; return; end
            if (!b[i].ov) continue;
            if (!hd) begin hd = 1; eh = int'(b[i].x); continue; end
            n++;
            el = (n > 255) ? 255 : n;
            x = int'(b[i].x);
            y = int'(b[i].y);
            if (n == 1 && !(x == 13 && y == 13))                 ec = 4;
            else if (n > 1 && (iabs(x - px) + iabs(y - py)) != 1) ec = 1;
            else if (x > 14 || y > 14 || ref_img[y][x])          ec = 2;
            else if (x == 1 && y == 1) begin ep = 1; ee = i; return; end
            else if (n == 256)                                    ec = 6;
            if (ec != 0) begin ee = i; return; end
            px = x; py = y;
        end
        ec = 3;
    endtask

    task automatic write_row(input int y, input logic [14:0] d, input bit upd);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_row = 4'(y); cfg_data = d;
        if (upd && y < 15) for (int x = 0; x < 15; x++) ref_img[y][x] = d[x];
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle row write) and check all 225 bits.
    task automatic do_start(input bit with_row, input int row, input logic [14:0] d, input bit poke);
        @(posedge clk); #1;
        start = 1'b1;
        if (with_row) begin
            cfg_we = 1'b1; cfg_row = 4'(row); cfg_data = d;
            for (int x = 0; x < 15; x++) ref_img[row][x] = d[x];
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        for (int k = 0; k < 225; k++) begin
            @(negedge clk);
            chk("stream_valid", in_valid, 1'b1);
            chk("stream_bit", maze, ref_img[k / 15][k % 15]);
            if (k == 0) chk("busy_in_send", busy, 1'b1);
            if (poke && k == 50) start = 1'b1;
            if (poke && k == 51) start = 1'b0;
        end
        @(negedge clk);
        chk("stream_end_valid", in_valid, 1'b0);
    endtask

    // Drive response beats and compare the DUT's verdict and timing to the model.
    task automatic run_resp(input beat_t b[$]);
        int ep, en, ec, eh, el, ee, d0, w;
        int drv_cyc [$];
        model(b, ep, en, ec, eh, el, ee);
        d0 = done_cnt;
        foreach (b[i]) begin
            @(posedge clk); #1;
            out_valid = b[i].ov; mnv = b[i].nv; out_x = b[i].x; out_y = b[i].y;
            drv_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        out_valid = 1'b0; mnv = 1'b0;
        w = 0;
        while (done_cnt == d0 && w < TO + 100) begin
            @(negedge clk); #1;
            w++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("pass", r_pass, ep);
        chk("nv_seen", r_nv, en);
        chk("fail_code", r_code, ec);
        chk("hdr_step", r_hdr, eh);
        chk("path_len", r_len, el);
        if (ee >= 0) chk("done_cycle", done_cyc, drv_cyc[ee] + 1);
        else         chk("timeout_cycle", done_cyc - fall_cyc, TO);
        @(negedge clk); @(negedge clk); #1;
        chk("hold_pass", pass, ep);
        chk("hold_code", fail_code, ec);
    endtask

    function automatic beat_t bt(input bit nv, input bit ov, input int x, input int y);
        beat_t r;
        r.nv = nv; r.ov = ov; r.x = 4'(x); r.y = 4'(y);
        return r;
    endfunction

    task automatic load_corridor();
        for (int y = 0; y < 15; y++)
            write_row(y, (y == 1) ? 15'h4001 : (y >= 2 && y <= 13) ? 15'h5FFF : 15'h7FFF, 1'b1);
    endtask

    beat_t bq[$];
    int    cx, cy;

    initial begin
        rst_n = 1'b0; cfg_we = 0; start = 0; gen_rand = 0; out_valid = 0; mnv = 0;
        cfg_row = 0; out_x = 0; out_y = 0; cfg_data = 0;
        #12;
        chk("rst_in_valid", in_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_pass", pass, 0); chk("rst_code", fail_code, 0); chk("rst_len", path_len, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Corridor, same-cycle row write with start, start poke while busy.
        load_corridor();
        write_row(0, 15'h0000, 1'b1);
        gen_rand = 1'b1;
        do_start(1'b1, 0, 15'h7FFF, 1'b1);
        gen_rand = 1'b0;
        write_row(1, 15'h7FFF, 1'b0);   // ignored while busy
        bq.delete();
        bq.push_back(bt(0, 1, 7, 0));
        for (int y = 13; y >= 1; y--) bq.push_back(bt(0, 1, 13, y));
        for (int x = 12; x >= 1; x--) bq.push_back(bt(0, 1, x, 1));
        run_resp(bq);
        chk("lit_pass", r_pass, 1); chk("lit_len", r_len, 25); chk("lit_hdr", r_hdr, 7);

        // Skip (13,5)->(13,3).
        write_row(15, 15'h0000, 1'b0);   // row 15 ignored
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete(); bq.push_back(bt(0, 1, 2, 0));
        for (int y = 13; y >= 5; y--) bq.push_back(bt(0, 1, 13, y));
        bq.push_back(bt(0, 1, 13, 3));
        bq.push_back(bt(0, 1, 13, 2));
        run_resp(bq);
        chk("lit_adj_code", r_code, 1); chk("lit_adj_len", r_len, 10); chk("lit_adj_pass", r_pass, 0);

        // Wall cell (12,12).
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete(); bq.push_back(bt(0, 1, 0, 0));
        bq.push_back(bt(0, 1, 13, 13)); bq.push_back(bt(0, 1, 13, 12)); bq.push_back(bt(0, 1, 12, 12));
        run_resp(bq);
        chk("lit_wall_code", r_code, 2); chk("lit_wall_len", r_len, 3);

        // maze_not_valid together with out_valid in PATH.
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete(); bq.push_back(bt(0, 1, 1, 0));
        bq.push_back(bt(0, 1, 13, 13)); bq.push_back(bt(0, 1, 13, 12)); bq.push_back(bt(1, 1, 13, 11));
        run_resp(bq);
        chk("lit_nv", r_nv, 1); chk("lit_nv_code", r_code, 0); chk("lit_nv_len", r_len, 2);

        // Path longer than 255 beats.
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete(); bq.push_back(bt(0, 1, 3, 0));
        for (int i = 1; i <= 260; i++) bq.push_back(bt(0, 1, 13, (i % 2) ? 13 : 12));
        run_resp(bq);
        chk("lit_long_code", r_code, 6); chk("lit_long_len", r_len, 255);

        // Silent solver -> timeout.
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete();
        run_resp(bq);
        chk("lit_tmo_code", r_code, 3);

        // Reset at bit 100 of SEND, then a full restart.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            chk("pre_rst_bit", maze, ref_img[k / 15][k % 15]);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", in_valid, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_code", fail_code, 0); chk("rst_mid_len", path_len, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_start(1'b0, 0, 15'h0, 1'b0);
        bq.delete(); bq.push_back(bt(1, 0, 0, 0));
        run_resp(bq);

        // Randomized mazes and paths.
        for (int it = 0; it < 8; it++) begin
            for (int y = 0; y < 15; y++) begin
                logic [14:0] d;
                d = 15'($urandom);
                if (it % 2 == 0) begin
                    if (y == 1) d = d & 15'h4001;
                    if (y >= 1 && y <= 13) d[13] = 1'b0;
                end
                write_row(y, d, 1'b1);
            end
            do_start(1'b0, 0, 15'h0, 1'b0);
            bq.delete();
            bq.push_back(bt(0, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
            cx = 13; cy = 13;
            if ($urandom % 10 == 0) begin cx = $urandom_range(0, 15); cy = $urandom_range(0, 15); end
            for (int i = 0, L = $urandom_range(1, 30); i < L; i++) begin
                if ($urandom % 4 == 0) bq.push_back(bt(0, 0, 0, 0));
                if ($urandom % 100 < 4) bq.push_back(bt(1, $urandom % 2, cx, cy));
                bq.push_back(bt(0, 1, cx, cy));
                if ($urandom % 100 < 85) begin
                    case ($urandom % 4)
                        0: cx = (cx + 1) % 16;
                        1: cx = (cx + 15) % 16;
                        2: cy = (cy + 1) % 16;
                        default: cy = (cy + 15) % 16;
                    endcase
                end else begin
                    cx = $urandom_range(0, 15); cy = $urandom_range(0, 15);
                end
            end
            if ($urandom % 10 < 7) bq.push_back(bt(1, 0, 0, 0));
            run_resp(bq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
